up_down_counter: RTL and testbench
==================================

Name: up_down_counter

Overview:
- Parameterised binary counter producing a free-running count value.
- Used as a timebase, event counter or address generator.
- Supports synchronous enable, parallel load, count direction select and terminal-count flags.
- Single clock domain, asynchronous active-low reset.

Parameters:
- WIDTH, 16, bit width of the count value and load value; legal range 2..64.
- RESET_VALUE, 0, value the count takes while reset is asserted; must fit in WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 = in reset.
- value  output  WIDTH  current count, registered.
- en  input  1  count enable; 1 = count this cycle.
- up_dn  input  1  direction; 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load strobe.
- load_value  input  WIDTH  value captured when load = 1.
- at_max  output  1  combinational; 1 when value == all ones.
- at_zero  output  1  combinational; 1 when value == 0.
- wrap  output  1  registered one-cycle pulse; count rolled over on the previous edge.

Behaviour:
- Clock and reset: one clock (clk); reset asynchronous and active-low.
- Reset: reset = 0 immediately forces value = RESET_VALUE and wrap = 0, independent of clk.
  - Release is synchronous in effect: the first update happens on the first rising clk edge with reset = 1.
- Priority on each rising clk edge (reset high):
  - load = 1: value <= load_value, wrap <= 0. en and up_dn are ignored.
  - else en = 1, up_dn = 1: value <= value + 1, modulo 2^WIDTH.
  - else en = 1, up_dn = 0: value <= value - 1, modulo 2^WIDTH.
  - else: value holds, wrap <= 0.
- Wrap-around:
  - Incrementing from all ones yields 0 and wrap <= 1 for exactly one cycle.
  - Decrementing from 0 yields all ones and wrap <= 1 for exactly one cycle.
  - Every other count step sets wrap <= 0.
- at_max and at_zero:
  - Decoded combinationally from value; direction-independent.
  - Both are valid during reset and reflect RESET_VALUE.
- Latency: value changes one clock after en/load are sampled; flags follow value combinationally.
- Changing up_dn mid-count takes effect on the next enabled edge; there is no turnaround cycle.
- Reset asserted mid-count aborts the operation immediately. No state survives except RESET_VALUE.
- All arithmetic is unsigned WIDTH-bit; the carry/borrow is used only to generate wrap.

Optional Feature:
- Macro: COUNTER_SATURATE_EN.
- Defined:
  - Counting saturates: increment at all ones holds at all ones; decrement at 0 holds at 0.
  - wrap is never asserted (tied 0).
  - load still permits any value.
- Undefined: modulo wrap-around behaviour as described in Behaviour.

Decomposition:
- Shared package counter_pkg:
  - Direction constants DIR_UP = 1'b1 and DIR_DN = 1'b0.
  - Helper function for the all-ones constant of a given width.
- One natural sub-module: counter_next_calc.
  - Purely combinational.
  - Computes the next value and the wrap condition from value, en, up_dn, load and load_value.
  - Honours COUNTER_SATURATE_EN.
- The top level holds the register, the reset logic and the flag decoders.

Test Plan:
- Reset and count up: hold reset = 0 for 3 clocks, then release with en = 1, up_dn = 1.
  - value reads 0 during reset, then 1, 2, 3... on successive edges; at_zero = 1 only while value = 0.
- Wrap up: load 16'hFFFE, then count up 3 edges.
  - value goes FFFF (at_max = 1), 0000 with wrap = 1 for one cycle, then 0001.
  - With COUNTER_SATURATE_EN, value sticks at FFFF and wrap stays 0.
- Wrap down: load 16'h0001, up_dn = 0, count 3 edges.
  - value goes 0000, FFFF with wrap = 1, then FFFE.
- Priority: load = 1 with load_value = 16'h1234 while en = 1 and up_dn = 1.
  - value = 1234 next cycle, not 1235; hold en = 0 for 4 cycles and value stays 1234.
- Async reset mid-count: count to 16'h0020, then drop reset between clock edges.
  - value = 0 before the next edge; after release, counting resumes from 0.
- Direction change: count up to 5, flip up_dn = 0.
  - Next edges give 4, 3; no skipped or repeated value.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg: shared direction constants and width helpers for the up/down counter
package counter_pkg;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;
  function automatic logic [63:0] all_ones(input int w);
    return (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
  endfunction
endpackage

// File: rtl/counter_next_calc.sv
// counter_next_calc: next count and wrap condition; COUNTER_SATURATE_EN selects saturating steps
module counter_next_calc
  import counter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             en_i,
  input  logic             up_dn_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic [WIDTH-1:0] value_o,
  output logic             wrap_o
);
  logic [WIDTH:0] step;
  // one step in the chosen direction; the top bit is the carry or borrow
  always_comb begin
    step = (up_dn_i == DIR_UP) ? {1'b0, value_i} + (WIDTH+1)'(1) : {1'b0, value_i} - (WIDTH+1)'(1);
`ifdef COUNTER_SATURATE_EN
    value_o = load_i ? load_value_i : (en_i && !step[WIDTH]) ? step[WIDTH-1:0] : value_i;
    wrap_o  = 1'b0;
`else
    value_o = load_i ? load_value_i : en_i ? step[WIDTH-1:0] : value_i;
    wrap_o  = !load_i && en_i && step[WIDTH];
`endif
  end
endmodule

// File: rtl/up_down_counter.sv
// up_down_counter: parameterised up/down counter with load, terminal flags and wrap pulse (COUNTER_SATURATE_EN saturates)
module up_down_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             at_max,
  output logic             at_zero,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(all_ones(WIDTH));
  logic [WIDTH-1:0] value_q, value_d;
  logic             wrap_q, wrap_d;
  counter_next_calc #(.WIDTH(WIDTH)) u_next (
    .value_i      (value_q),
    .en_i         (en),
    .up_dn_i      (up_dn),
    .load_i       (load),
    .load_value_i (load_value),
    .value_o      (value_d),
    .wrap_o       (wrap_d)
  );
  // count register and wrap pulse, cleared immediately by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= RESET_VALUE;
      wrap_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      wrap_q  <= wrap_d;
    end
  end
  assign value   = value_q;
  assign wrap    = wrap_q;
  assign at_max  = (value_q == MAX);
  assign at_zero = (value_q == '0);
endmodule

// File: tb/tb_up_down_counter.sv
// tb_up_down_counter: directed and randomized checks of up_down_counter against an arithmetic model
module tb_up_down_counter;
  localparam longint MAXV = 65535;
  logic        clk = 0;
  logic        reset = 1;
  logic        en = 0;
  logic        up_dn = 1;
  logic        load = 0;
  logic [15:0] load_value = '0;
  logic [15:0] value;
  logic        at_max, at_zero, wrap;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  longint      m = 0;
  bit          mw = 0;

  up_down_counter #(.WIDTH(16), .RESET_VALUE(16'h0000)) dut (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_value(load_value), .value(value), .at_max(at_max),
    .at_zero(at_zero), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".value"}, 64'(value), 64'(m));
    check({tag, ".wrap"}, 64'(wrap), 64'(mw));
    check({tag, ".at_max"}, 64'(at_max), 64'(m == MAXV));
    check({tag, ".at_zero"}, 64'(at_zero), 64'(m == 0));
  endtask

  task automatic model_edge(input bit l, input longint lv, input bit e, input bit u);
    longint n;
    if (!reset) begin m = 0; mw = 0; end
    else if (l) begin m = lv; mw = 0; end
    else if (e) begin
      n = u ? m + 1 : m - 1;
      if (n > MAXV || n < 0) begin
`ifdef COUNTER_SATURATE_EN
        mw = 0;
`else
        m = (n + MAXV + 1) % (MAXV + 1);
        mw = 1;
`endif
      end else begin m = n; mw = 0; end
    end else mw = 0;
  endtask

  task automatic cyc(input string tag, input bit l, input logic [15:0] lv, input bit e, input bit u);
    load = l; load_value = lv; en = e; up_dn = u;
    @(posedge clk);
    model_edge(l, longint'(lv), e, u);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset_pulse(input string tag);
    #3 reset = 0;
    #1;
    m = 0; mw = 0;
    check_all({tag, ".async"});
    cyc({tag, ".held"}, 0, 16'h0, 1, 1);
    reset = 1;
  endtask

  initial begin
    #2 reset = 0;
    #1 check_all("reset_async");
    for (int i = 0; i < 3; i++) cyc("in_reset", 0, 16'h0, 1, 1);
    reset = 1;
    for (int i = 0; i < 3; i++) cyc("count_up", 0, 16'h0, 1, 1);
    cyc("load_fffe", 1, 16'hFFFE, 0, 1);
    for (int i = 0; i < 3; i++) cyc("wrap_up", 0, 16'h0, 1, 1);
    cyc("load_0001", 1, 16'h0001, 0, 0);
    for (int i = 0; i < 3; i++) cyc("wrap_dn", 0, 16'h0, 1, 0);
    cyc("prio_load", 1, 16'h1234, 1, 1);
    for (int i = 0; i < 4; i++) cyc("hold", 0, 16'h0, 0, 1);
    cyc("load_1f", 1, 16'h001F, 0, 1);
    cyc("to_20", 0, 16'h0, 1, 1);
    async_reset_pulse("mid");
    for (int i = 0; i < 2; i++) cyc("resume", 0, 16'h0, 1, 1);
    cyc("load_0", 1, 16'h0000, 0, 1);
    for (int i = 0; i < 5; i++) cyc("up_to5", 0, 16'h0, 1, 1);
    for (int i = 0; i < 2; i++) cyc("dir_dn", 0, 16'h0, 1, 0);
    for (int i = 0; i < 400; i++) begin
      logic [15:0] lv;
      int          sel;
      sel = $urandom_range(0, 3);
      lv = (sel == 0) ? 16'hFFFF : (sel == 1) ? 16'h0000 : (sel == 2) ? 16'($urandom_range(0, 3) + 16'hFFFC) : 16'($urandom);
      if ($urandom_range(0, 59) == 0) async_reset_pulse("rnd");
      else cyc("rnd", $urandom_range(0, 11) == 0, lv, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
